tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 43 ++++
 rtl/tmds_symbol_decode.sv | 56 +++++
 rtl/tmds_channel_decoder.sv | 151 +++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants (control tokens, TERC4 table, guard bands) and the
// receive alignment state type; the transmit-side encoder uses the same constants.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_CODE_CH02 = 10'b1011001100;
    localparam logic [9:0] GUARD_CODE_CH1  = 10'b0100110011;

    typedef enum logic {
        StSearch = 1'b0,
        StLocked = 1'b1
    } tmds_align_state_e;

    function automatic logic [9:0] terc4_code(input logic [3:0] nib);
        logic [9:0] code;
        code = '0;
        case (nib)
            4'h0: code = 10'b1010011100;
            4'h1: code = 10'b1001100011;
            4'h2: code = 10'b1011100100;
            4'h3: code = 10'b1011100010;
            4'h4: code = 10'b0101110001;
            4'h5: code = 10'b0100011110;
            4'h6: code = 10'b0110001110;
            4'h7: code = 10'b0100111100;
            4'h8: code = 10'b1011001100;
            4'h9: code = 10'b0100111001;
            4'ha: code = 10'b0110011100;
            4'hb: code = 10'b1011000110;
            4'hc: code = 10'b1010001110;
            4'hd: code = 10'b1001110001;
            4'he: code = 10'b0101100011;
            4'hf: code = 10'b1011000011;
            default: code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into every interpretation
// (video, control, TERC4, guard band) at once.
module tmds_symbol_decode
    import tmds_pkg::*;
#(
    parameter int unsigned CHANNEL = 0
) (
    input  logic [9:0] sym,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic [3:0] terc4,
    output logic       is_ctrl,
    output logic       is_terc4,
    output logic       is_guard
);

    localparam logic [9:0] GUARD_CODE = (CHANNEL == 1) ? GUARD_CODE_CH1 : GUARD_CODE_CH02;

    logic [7:0] d;

    always_comb begin
        d    = sym[9] ? ~sym[7:0] : sym[7:0];
        data = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        ctrl    = 2'b00;
        is_ctrl = 1'b0;
        case (sym)
            CTRL_TOKEN_00: begin ctrl = 2'b00; is_ctrl = 1'b1; end
            CTRL_TOKEN_01: begin ctrl = 2'b01; is_ctrl = 1'b1; end
            CTRL_TOKEN_10: begin ctrl = 2'b10; is_ctrl = 1'b1; end
            CTRL_TOKEN_11: begin ctrl = 2'b11; is_ctrl = 1'b1; end
            default:       begin ctrl = 2'b00; is_ctrl = 1'b0; end
        endcase
    end

    always_comb begin
        terc4    = '0;
        is_terc4 = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (sym == terc4_code(4'(n))) begin
                terc4    = 4'(n);
                is_terc4 = 1'b1;
            end
        end
    end

    // Guard codes overlap TERC4 entries; both flags are reported independently.
    assign is_guard = (sym == GUARD_CODE);

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit-alignment hunt on control tokens plus 2-stage decode.
// Optional lock-loss statistics are built when TMDS_DEC_STATS_EN is defined.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned CHANNEL       = 0,
    parameter int unsigned LOCK_COUNT    = 8,
    parameter int unsigned SEARCH_DWELL  = 2048,
    parameter int unsigned TOKEN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] raw_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic [3:0] terc4,
    output logic       is_ctrl,
    output logic       is_terc4,
    output logic       is_guard,
    output logic       sym_valid,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned RUN_W   = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int unsigned DWELL_W = (SEARCH_DWELL > 1) ? $clog2(SEARCH_DWELL) : 1;
    localparam int unsigned TMO_W   = (TOKEN_TIMEOUT > 1) ? $clog2(TOKEN_TIMEOUT) : 1;

    logic [9:0]         prev_q, sym_q;
    logic [19:0]        cat;
    tmds_align_state_e  state_q, state_d;
    logic [3:0]         offset_q, offset_d, offset_next;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [7:0] dec_data;
    logic [1:0] dec_ctrl;
    logic [3:0] dec_terc4;
    logic       dec_is_ctrl, dec_is_terc4, dec_is_guard;

    assign cat = {raw_in, prev_q};

    tmds_symbol_decode #(
        .CHANNEL(CHANNEL)
    ) u_decode (
        .sym      (sym_q),
        .data     (dec_data),
        .ctrl     (dec_ctrl),
        .terc4    (dec_terc4),
        .is_ctrl  (dec_is_ctrl),
        .is_terc4 (dec_is_terc4),
        .is_guard (dec_is_guard)
    );

    assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        dwell_d  = dwell_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            StSearch: begin
                // Lock has priority over a dwell expiry in the same cycle.
                if (dec_is_ctrl && run_q == RUN_W'(LOCK_COUNT - 1)) begin
                    state_d = StLocked;
                    tmo_d   = '0;
                    run_d   = '0;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_W'(SEARCH_DWELL - 1)) begin
                    offset_d = offset_next;
                    run_d    = '0;
                    dwell_d  = '0;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                    run_d   = dec_is_ctrl ? run_q + RUN_W'(1) : '0;
                end
            end
            StLocked: begin
                if (dec_is_ctrl) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_W'(TOKEN_TIMEOUT - 1)) begin
                    state_d  = StSearch;
                    offset_d = offset_next;
                    run_d    = '0;
                    dwell_d  = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q    <= '0;
            sym_q     <= '0;
            state_q   <= StSearch;
            offset_q  <= '0;
            run_q     <= '0;
            dwell_q   <= '0;
            tmo_q     <= '0;
            data      <= '0;
            ctrl      <= '0;
            terc4     <= '0;
            is_ctrl   <= 1'b0;
            is_terc4  <= 1'b0;
            is_guard  <= 1'b0;
            sym_valid <= 1'b0;
        end else begin
            prev_q    <= raw_in;
            sym_q     <= 10'(cat >> offset_q);
            state_q   <= state_d;
            offset_q  <= offset_d;
            run_q     <= run_d;
            dwell_q   <= dwell_d;
            tmo_q     <= tmo_d;
            data      <= dec_data;
            ctrl      <= dec_ctrl;
            terc4     <= dec_terc4;
            is_ctrl   <= dec_is_ctrl;
            is_terc4  <= dec_is_terc4;
            is_guard  <= dec_is_guard;
            sym_valid <= (state_q == StLocked);
        end
    end

    assign locked     = (state_q == StLocked);
    assign bit_offset = offset_q;

`ifdef TMDS_DEC_STATS_EN
    logic [7:0] loss_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_q <= '0;
        end else if (state_q == StLocked && state_d == StSearch && loss_q != 8'hff) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_q;
`else
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Randomized bench for tmds_channel_decoder: a shifted TMDS bit stream is fed in and
// every cycle is compared with a behavioural model, plus targeted scenario checks.
module tb_tmds_channel_decoder;

    localparam int unsigned LOCK_COUNT    = 8;
    localparam int unsigned SEARCH_DWELL  = 2048;
    localparam int unsigned TOKEN_TIMEOUT = 4096;
    localparam int unsigned SHIFT         = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       rst_next = 1'b0;
    logic [9:0] raw_in = '0;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [3:0] terc4;
    logic       is_ctrl, is_terc4, is_guard, sym_valid, locked;
    logic [3:0] bit_offset;
    logic [7:0] lock_loss_count;

    tmds_channel_decoder #(
        .CHANNEL       (0),
        .LOCK_COUNT    (LOCK_COUNT),
        .SEARCH_DWELL  (SEARCH_DWELL),
        .TOKEN_TIMEOUT (TOKEN_TIMEOUT)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .raw_in          (raw_in),
        .data            (data),
        .ctrl            (ctrl),
        .terc4           (terc4),
        .is_ctrl         (is_ctrl),
        .is_terc4        (is_terc4),
        .is_guard        (is_guard),
        .sym_valid       (sym_valid),
        .locked          (locked),
        .bit_offset      (bit_offset),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [9:0] ctrl_tok [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};
    logic [9:0] terc4_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    logic [9:0] guard0 = 10'b1011001100;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic [3:0] terc4;
        logic       is_ctrl;
        logic       is_terc4;
        logic       is_guard;
    } dec_t;

    function automatic dec_t ref_decode(input logic [9:0] s);
        dec_t r;
        logic [7:0] d, x;
        r = '0;
        d = s[9] ? ~s[7:0] : s[7:0];
        x = d ^ {d[6:0], 1'b0};
        if (!s[8]) x = ~x;
        r.data = {x[7:1], d[0]};
        for (int k = 0; k < 4; k++) if (s == ctrl_tok[k]) begin r.is_ctrl = 1'b1; r.ctrl = 2'(k); end
        for (int k = 0; k < 16; k++) if (s == terc4_tab[k]) begin r.is_terc4 = 1'b1; r.terc4 = 4'(k); end
        r.is_guard = (s == guard0);
        return r;
    endfunction

    function automatic logic [9:0] tmds_encode(input logic [7:0] b, input bit inv);
        logic [8:0] q;
        bit xn;
        xn = ($countones(b) > 4) || ($countones(b) == 4 && !b[0]);
        q[0] = b[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
        q[8] = !xn;
        return inv ? {1'b1, q[8], ~q[7:0]} : {1'b0, q};
    endfunction

    // Behavioural model state.
    bit         m_locked;
    int         m_off, m_run, m_dwell, m_tmo, m_loss;
    logic [9:0] m_s1, m_prev;
    dec_t       e_dec;
    bit         e_valid;
    int         cyc = 0;
    logic [19:0] car = '0;

    typedef struct {
        int          due;
        logic [17:0] exp;
        logic [17:0] mask;
        string       tag;
    } due_t;
    due_t dues[$];

    logic [17:0] o18;
    logic [30:0] got_all;
    assign o18 = {sym_valid, is_ctrl, is_terc4, is_guard, ctrl, terc4, data};
    assign got_all = {data, ctrl, terc4, is_ctrl, is_terc4, is_guard, sym_valid, locked,
                      bit_offset, lock_loss_count};

    function automatic int exp_loss();
`ifdef TMDS_DEC_STATS_EN
        return m_loss;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_locked = 0; m_off = 0; m_run = 0; m_dwell = 0; m_tmo = 0; m_loss = 0;
        m_s1 = '0; m_prev = '0; e_dec = '0; e_valid = 0;
    endtask

    task automatic model_edge(input logic [9:0] w);
        dec_t r;
        int   old_off;
        logic [19:0] c;
        r = ref_decode(m_s1);
        e_dec = r;
        e_valid = m_locked;
        old_off = m_off;
        if (!m_locked) begin
            if (r.is_ctrl && m_run + 1 == int'(LOCK_COUNT)) begin
                m_locked = 1; m_tmo = 0; m_run = 0; m_dwell = 0;
            end else if (m_dwell == int'(SEARCH_DWELL) - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_dwell = 0;
            end else begin
                m_dwell++;
                m_run = r.is_ctrl ? m_run + 1 : 0;
            end
        end else begin
            if (r.is_ctrl) m_tmo = 0;
            else if (m_tmo == int'(TOKEN_TIMEOUT) - 1) begin
                m_locked = 0; m_off = (m_off + 1) % 10; m_run = 0; m_dwell = 0;
                if (m_loss < 255) m_loss++;
            end else m_tmo++;
        end
        c = {w, m_prev};
        m_s1 = 10'(c >> old_off);
        m_prev = w;
    endtask

    task automatic step(input logic [9:0] w);
        logic [30:0] exp_all;
        @(negedge clk);
        resetn = rst_next;
        raw_in = w;
        @(posedge clk);
        cyc++;
        #1;
        if (!resetn) model_reset();
        else model_edge(w);
        exp_all = {e_dec.data, e_dec.ctrl, e_dec.terc4, e_dec.is_ctrl, e_dec.is_terc4,
                   e_dec.is_guard, e_valid, m_locked, 4'(m_off), 8'(exp_loss())};
        check_eq("cycle", 32'(got_all), 32'(exp_all));
        while (dues.size() > 0 && dues[0].due <= cyc) begin
            due_t e;
            e = dues.pop_front();
            check_eq(e.tag, 32'(o18 & e.mask), 32'(e.exp & e.mask));
        end
    endtask

    // Emit one symbol on the wire delayed by SHIFT bits.
    task automatic send_sym(input logic [9:0] s);
        logic [19:0] t;
        t = ({10'b0, s} << SHIFT) | car;
        car = {10'b0, t[19:10]};
        step(t[9:0]);
    endtask

    task automatic send_video(input logic [7:0] b, input bit track);
        if (track) dues.push_back('{cyc + 3, {1'b1, 1'b0, 2'b00, 2'b00, 4'h0, b},
                                   18'b1_1_00_00_0000_11111111, "video_rt"});
        send_sym(tmds_encode(b, bit'($urandom_range(1))));
    endtask

    task automatic send_terc4(input logic [9:0] s, input logic [3:0] nib, input bit guard);
        dues.push_back('{cyc + 3, {1'b0, 1'b0, 1'b1, guard, 2'b00, nib, 8'h00},
                       18'b0_0_11_00_1111_00000000, "terc4_guard"});
        send_sym(s);
    endtask

    task automatic hunt_to(input int target);
        int prev_off;
        for (int i = 0; i < 10 * int'(SEARCH_DWELL) && m_off != target; i++) begin
            prev_off = m_off;
            send_video(8'($urandom), 1'b0);
            if (m_off != prev_off) check_eq("hunt_step", 32'(bit_offset), 32'((prev_off + 1) % 10));
        end
        check_eq("hunt_reached", 32'(bit_offset), 32'(target));
    endtask

    task automatic lock_sequence();
        hunt_to(3);
        repeat (20) send_sym(ctrl_tok[0]);
        check_eq("lock_rise", 32'(locked), 32'd1);
        check_eq("lock_off", 32'(bit_offset), 32'd3);
        check_eq("lock_ctrl", 32'({is_ctrl, ctrl}), 32'b100);
        check_eq("lock_valid", 32'(sym_valid), 32'd1);
    endtask

    logic [7:0] rt_bytes [5] = '{8'h00, 8'h55, 8'haa, 8'hff, 8'h10};

    initial begin
        model_reset();
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_flags", 32'({is_ctrl, is_terc4, is_guard, sym_valid, locked}), 32'd0);
        check_eq("rst_offset", 32'(bit_offset), 32'd0);
        check_eq("rst_loss", 32'(lock_loss_count), 32'd0);
        rst_next = 1'b1;

        lock_sequence();

        for (int i = 0; i < 5; i++) send_video(rt_bytes[i], 1'b1);
        for (int i = 0; i < 10; i++) send_video(8'($urandom), 1'b1);
        send_terc4(guard0, 4'h8, 1'b1);
        send_terc4(terc4_tab[15], 4'hf, 1'b0);
        send_terc4(terc4_tab[$urandom_range(15)], 4'h0, 1'b0);
        dues.pop_back();
        repeat (4) send_video(8'($urandom), 1'b1);

        for (int i = 0; i < 2 * int'(TOKEN_TIMEOUT) && m_locked; i++) send_video(8'($urandom), 1'b0);
        check_eq("loss_locked", 32'(locked), 32'd0);
        check_eq("loss_offset", 32'(bit_offset), 32'd4);
`ifdef TMDS_DEC_STATS_EN
        check_eq("loss_count", 32'(lock_loss_count), 32'd1);
`else
        check_eq("loss_count", 32'(lock_loss_count), 32'd0);
`endif
        send_video(8'($urandom), 1'b0);
        check_eq("loss_valid", 32'(sym_valid), 32'd0);

        hunt_to(9);
        repeat (SEARCH_DWELL) send_video(8'($urandom), 1'b0);
        check_eq("wrap_offset", 32'(bit_offset), 32'd0);

        lock_sequence();
        repeat (5) send_video(8'($urandom), 1'b0);
        #2 resetn = 1'b0;
        rst_next = 1'b0;
        #1;
        check_eq("arst_data", 32'({data, ctrl, terc4}), 32'd0);
        check_eq("arst_flags", 32'({is_ctrl, is_terc4, is_guard, sym_valid, locked}), 32'd0);
        check_eq("arst_offset", 32'(bit_offset), 32'd0);
        check_eq("arst_loss", 32'(lock_loss_count), 32'd0);
        model_reset();
        dues.delete();
        repeat (2) send_video(8'($urandom), 1'b0);
        rst_next = 1'b1;

        lock_sequence();
        repeat (4) send_video(8'($urandom), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
